// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: 2-flop synchronizer, tick divider, 3-sample majority vote, 8N1 framing.
// Optional even-parity bit is compiled in with the UART_RX_PARITY_EN macro.
`timescale 1ns/1ps
module uart_rx_oversample #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_50m,
    input  logic       reset_b,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_busy,
    output logic [2:0] state_dbg
);

    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVERSAMPLE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic          sync1, rxs;
    logic [2:0]    state;
    logic [CW-1:0] div_cnt;
    logic [TW-1:0] tc;
    logic          samp_a, samp_b;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic          tick, mid_a, mid_b, decide, bit_end, maj;

    always_ff @(posedge clk_50m or posedge reset_b) begin
        if (reset_b) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            rxs   <= sync1;
        end
    end

    assign tick    = (state != S_IDLE) && (div_cnt == CW'(DIV - 1));
    assign mid_a   = tick && (tc == TW'(M - 1));
    assign mid_b   = tick && (tc == TW'(M));
    assign decide  = tick && (tc == TW'(M + 1));
    assign bit_end = tick && (tc == TW'(OVERSAMPLE - 1));
    assign maj     = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);

    // Divider and tick counter sit at zero in IDLE so sampling phase is set by the start edge.
    always_ff @(posedge clk_50m or posedge reset_b) begin
        if (reset_b) begin
            div_cnt <= '0;
            tc      <= '0;
        end else if (state == S_IDLE) begin
            div_cnt <= '0;
            tc      <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            tc      <= (tc == TW'(OVERSAMPLE - 1)) ? '0 : tc + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // rx_valid is a one-cycle strobe with no back-pressure: the consumer must take rx_data on it.
    always_ff @(posedge clk_50m or posedge reset_b) begin
        if (reset_b) begin
            state        <= S_IDLE;
            samp_a       <= 1'b1;
            samp_b       <= 1'b1;
            shift        <= 8'h00;
            bit_idx      <= 3'd0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
            if (mid_a) samp_a <= rxs;
            if (mid_b) samp_b <= rxs;
            case (state)
                S_IDLE: begin
                    if (!rxs) state <= S_START;
                end
                S_START: begin
                    if (decide && maj) begin
                        state <= S_IDLE;
                    end else if (bit_end) begin
                        state   <= S_DATA;
                        bit_idx <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (decide) shift <= {maj, shift[7:1]};
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    // Even parity: data ones plus parity bit must be even.
                    if (decide) bit_idx[0] <= (^shift) ^ maj;
                    if (bit_end) state <= S_STOP;
                end
`endif
                S_STOP: begin
                    if (decide) begin
                        state <= S_IDLE;
                        if (!maj) begin
                            rx_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (bit_idx[0]) begin
                            rx_parity_err <= 1'b1;
`endif
                        end else begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign rx_parity_err = 1'b0;
`endif

    assign rx_busy   = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: a default-rate instance for latency/glitch checks and a
// fast instance (DIV = 2) for directed and randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_oversample;
  localparam int OS    = 16;
  localparam int M     = OS / 2;
  localparam int DIV_S = 50_000_000 / (9600 * OS);
  localparam int DIV_F = 2;
  localparam int BIT_S = DIV_S * OS;
  localparam int BIT_F = DIV_F * OS;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd_s = 1'b1;
  logic rxd_f = 1'b1;
  logic [7:0] data_s, data_f;
  logic valid_s, valid_f, fe_s, fe_f, pe_s, pe_f, busy_s, busy_f;
  logic [2:0] st_s, st_f;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [9:0] exp_q[$];
  logic [7:0] last_good;
  logic [7:0] model_data;

  int slow_valid_n = 0;
  int slow_fe_n = 0;
  int slow_valid_cyc = 0;
  logic [7:0] slow_data = 8'h00;
  logic slow_prev_valid = 1'b0;
  logic slow_busy_after = 1'b1;

  uart_rx_oversample #(.CLK_HZ(50_000_000), .BAUD(9600), .OVERSAMPLE(OS)) dut_slow (
    .clk_50m(clk), .reset_b(rst), .uart_rxd(rxd_s), .rx_data(data_s), .rx_valid(valid_s),
    .rx_frame_err(fe_s), .rx_parity_err(pe_s), .rx_busy(busy_s), .state_dbg(st_s));

  uart_rx_oversample #(.CLK_HZ(50_000_000), .BAUD(1_562_500), .OVERSAMPLE(OS)) dut_fast (
    .clk_50m(clk), .reset_b(rst), .uart_rxd(rxd_f), .rx_data(data_f), .rx_valid(valid_f),
    .rx_frame_err(fe_f), .rx_parity_err(pe_f), .rx_busy(busy_f), .state_dbg(st_f));

  // clock / reset
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive_bit(input bit fast, input logic v);
    if (fast) rxd_f = v; else rxd_s = v;
    repeat (fast ? BIT_F : BIT_S) @(negedge clk);
  endtask

  task automatic send_frame(input bit fast, input logic [7:0] d, input logic par, input logic stop);
    drive_bit(fast, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(fast, d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(fast, par);
`else
    if (par === 1'bx) $display("unreachable");
`endif
    drive_bit(fast, stop);
  endtask

  task automatic idle_bits(input int n);
    rxd_f = 1'b1;
    repeat (n * BIT_F) @(negedge clk);
  endtask

  // Frame-level model: a bad stop wins over a bad parity, only a clean frame updates data.
  task automatic send_expect(input logic [7:0] d, input logic par, input logic stop);
    logic par_bad;
`ifdef UART_RX_PARITY_EN
    par_bad = ((^d) ^ par);
`else
    par_bad = 1'b0;
`endif
    if (!stop) exp_q.push_back({2'd2, last_good});
    else if (par_bad) exp_q.push_back({2'd3, last_good});
    else begin
      exp_q.push_back({2'd1, d});
      last_good = d;
    end
    send_frame(1'b1, d, par, stop);
  endtask

  // scoreboard for the fast instance
  always @(negedge clk) begin
    logic [9:0] e;
    logic [1:0] kind;
    if (rst) begin
      model_data = 8'h00;
    end else begin
      check("valid_and_frame_err", {31'd0, valid_f & fe_f}, 32'd0);
      if (valid_f | fe_f | pe_f) begin
        kind = valid_f ? 2'd1 : (fe_f ? 2'd2 : 2'd3);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {22'd0, kind, data_f}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind_data", {22'd0, kind, data_f}, {22'd0, e});
          if (e[9:8] == 2'd1) model_data = e[7:0];
        end
      end else begin
        check("rx_data_stable", {24'd0, data_f}, {24'd0, model_data});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (slow_prev_valid) slow_busy_after = busy_s;
      if (valid_s) begin
        slow_valid_n++;
        slow_valid_cyc = cyc;
        slow_data = data_s;
      end
      if (fe_s) slow_fe_n++;
      slow_prev_valid = valid_s;
    end
  end

  initial begin
    int c0;
    int lat;
    int exp_lat;
    int k;
    bit stop;
    logic [7:0] d;
    logic par;
    last_good = 8'h00;

    repeat (5) @(negedge clk);
    check("reset_data", {24'd0, data_f}, 32'h00);
    check("reset_pulses", {29'd0, valid_f, fe_f, pe_f}, 32'd0);
    check("reset_busy", {31'd0, busy_f}, 32'd0);
    check("reset_slow_busy", {31'd0, busy_s}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 2 us glitch on the default-rate instance
    rxd_s = 1'b0;
    repeat (100) @(negedge clk);
    check("glitch_busy_high", {31'd0, busy_s}, 32'd1);
    rxd_s = 1'b1;
    for (k = 0; k < DIV_S * (M + 2) + 20; k++) begin
      if (!busy_s) break;
      @(negedge clk);
    end
    check("glitch_busy_returns", {31'd0, busy_s}, 32'd0);
    check("glitch_no_pulse", slow_valid_n + slow_fe_n, 32'd0);
    repeat (BIT_S) @(negedge clk);

    // 0x55 at default rate with latency window
    c0 = cyc;
`ifdef UART_RX_PARITY_EN
    send_frame(1'b0, 8'h55, 1'b0, 1'b1);
`else
    send_frame(1'b0, 8'h55, 1'b0, 1'b1);
`endif
    repeat (4) @(negedge clk);
    check("slow_valid_count", slow_valid_n, 32'd1);
    check("slow_data", {24'd0, slow_data}, 32'h55);
    check("slow_frame_err", slow_fe_n, 32'd0);
    lat = slow_valid_cyc - c0;
    exp_lat = DIV_S * (OS * NB + M + 2) + 3;
    check("slow_latency_window", {31'd0, (lat >= exp_lat - 1) && (lat <= exp_lat + 1)}, 32'd1);
    check("slow_busy_after_valid", {31'd0, slow_busy_after}, 32'd0);

    // framing error keeps previous data
    idle_bits(2);
    send_expect(8'h3C, ^8'h3C, 1'b1);
    send_expect(8'hA3, ^8'hA3, 1'b0);
    idle_bits(3);
    check("frame_err_data_kept", {24'd0, data_f}, 32'h3C);

    // back-to-back frames
    send_expect(8'h01, ^8'h01, 1'b1);
    send_expect(8'hFE, ^8'hFE, 1'b1);
    idle_bits(2);
    check("b2b_last_data", {24'd0, data_f}, 32'hFE);

`ifdef UART_RX_PARITY_EN
    send_expect(8'h07, 1'b1, 1'b1);
    send_expect(8'h07, 1'b0, 1'b1);
    idle_bits(2);
    check("parity_data", {24'd0, data_f}, 32'h07);
`endif

    // reset during bit 4 of 0x81
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    rxd_f = 1'b0;
    repeat (BIT_F / 2) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy_f}, 32'd1);
    rst = 1'b1;
    #1;
    check("midframe_reset_data", {24'd0, data_f}, 32'h00);
    check("midframe_reset_pulses", {29'd0, valid_f, fe_f, pe_f}, 32'd0);
    check("midframe_reset_busy", {31'd0, busy_f}, 32'd0);
    rxd_f = 1'b1;
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_bits(2);
    send_expect(8'h42, ^8'h42, 1'b1);
    idle_bits(2);
    check("after_reset_data", {24'd0, data_f}, 32'h42);

    // randomized frames
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
      par = 1'($urandom_range(0, 1));
`else
      par = ^d;
`endif
      send_expect(d, par, stop);
      idle_bits(stop ? $urandom_range(0, 2) : 2);
    end
    idle_bits(3);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
